// File: rtl/seq_pkg.sv
// Shared types and constant helpers for the sequencer step agent.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_SETTLE,
    ST_DONE
  } seq_step_st_t;

  // A one-entry table still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Load/decrement down-counter that saturates at zero; shared by the ack-wait
// and settle phases of the step agent.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/seq_step_agent.sv
// Responder for one sequencer start/ready/done lane: sends up to NUM_CMDS
// configuration words on a valid/ack port, waits a settle delay, reports done.
module seq_step_agent
  import seq_pkg::*;
#(
  parameter int NUM_CMDS    = 4,
  parameter int CMD_W       = 32,
  parameter int ACK_TIMEOUT = 1000,
  parameter int SETTLE      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_CMDS*CMD_W-1:0]     cmd_table,
  input  logic [$clog2(NUM_CMDS+1)-1:0] cmd_count,
  input  logic                          seq_start,
  output logic                          seq_rdy,
  output logic                          seq_done,
  output logic                          err,
  output logic                          req_valid,
  output logic [CMD_W-1:0]              req_data,
  input  logic                          req_ack
);

  localparam int CNT_W = $clog2(NUM_CMDS + 1);
  localparam int IDX_W = clog2_min1(NUM_CMDS);
  localparam int TMR_W = $clog2(max_int(ACK_TIMEOUT, SETTLE) + 1);
  localparam logic [TMR_W-1:0] ACK_LOAD    = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE);
  localparam logic [CNT_W-1:0] MAX_COUNT   = CNT_W'(NUM_CMDS);

  seq_step_st_t     st_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             start_q_reg;

  logic             start_re;
  logic             start_ok;
  logic             ack_hit;
  logic             last_word;
  logic [CNT_W-1:0] eff_count;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_load_val;
  logic [CMD_W-1:0] cmd_word [NUM_CMDS];

  generate
    for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_word
      assign cmd_word[gi] = cmd_table[gi*CMD_W +: CMD_W];
    end
  endgenerate

  // Only an edge starts a step, so a level left high through DONE is inert.
  assign start_re  = seq_start & ~start_q_reg;
  assign start_ok  = start_re & enable & ((st_reg == ST_IDLE) || (st_reg == ST_DONE));
  assign eff_count = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
  assign ack_hit   = req_valid & req_ack;
  assign last_word = (CNT_W'(idx_reg) == (eff_count - CNT_W'(1)));

  // An ack in the cycle the timer reads zero is checked first, so it wins.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    tmr_load_val = SETTLE_LOAD;
    case (st_reg)
      ST_IDLE, ST_DONE: tmr_load = start_ok && (eff_count == '0);
      ST_ISSUE: begin
        tmr_load     = 1'b1;
        tmr_load_val = ACK_LOAD;
      end
      ST_WAIT_ACK: begin
        if (ack_hit) tmr_load = last_word;
        else         tmr_dec  = ~tmr_zero;
      end
      ST_SETTLE: tmr_dec = ~tmr_zero;
      default: ;
    endcase
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg      <= ST_IDLE;
      idx_reg     <= '0;
      start_q_reg <= 1'b0;
      seq_rdy     <= 1'b0;
      seq_done    <= 1'b0;
      err         <= 1'b0;
      req_valid   <= 1'b0;
      req_data    <= '0;
    end else begin
      start_q_reg <= seq_start;
      case (st_reg)
        ST_IDLE, ST_DONE: begin
          seq_rdy <= (st_reg == ST_IDLE) & enable & ~start_ok;
          if (start_ok) begin
            seq_done <= 1'b0;
            err      <= 1'b0;
            idx_reg  <= '0;
            st_reg   <= (eff_count != '0) ? ST_ISSUE : ST_SETTLE;
          end
        end
        ST_ISSUE: begin
          req_valid <= 1'b1;
          req_data  <= cmd_word[idx_reg];
          st_reg    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_hit) begin
            req_valid <= 1'b0;
            if (last_word) begin
              st_reg <= ST_SETTLE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
              st_reg  <= ST_ISSUE;
            end
          end else if (tmr_zero) begin
            req_valid <= 1'b0;
            err       <= 1'b1;
            seq_done  <= 1'b1;
            st_reg    <= ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            seq_done <= 1'b1;
            st_reg   <= ST_DONE;
          end
        end
        default: st_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_agent.sv
// Bench for seq_step_agent: a timeline model predicts each step's word windows
// and done cycle from the planned ack delays; outputs are compared every cycle.
module tb_seq_step_agent;

  localparam int NUM_CMDS = 4;
  localparam int CMD_W    = 32;
  localparam int ACK_T    = 8;
  localparam int SETTLE_C = 16;
  localparam int CNT_W    = $clog2(NUM_CMDS + 1);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      enable = 1'b0;
  logic [NUM_CMDS*CMD_W-1:0] cmd_table = '0;
  logic [CNT_W-1:0]          cmd_count = '0;
  logic                      seq_start = 1'b0;
  logic                      seq_rdy, seq_done, err, req_valid;
  logic [CMD_W-1:0]          req_data;
  logic                      req_ack = 1'b0;

  seq_step_agent #(
    .NUM_CMDS    (NUM_CMDS),
    .CMD_W       (CMD_W),
    .ACK_TIMEOUT (ACK_T),
    .SETTLE      (SETTLE_C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cmd_table (cmd_table),
    .cmd_count (cmd_count),
    .seq_start (seq_start),
    .seq_rdy   (seq_rdy),
    .seq_done  (seq_done),
    .err       (err),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Timeline model: cycle n is the interval after rising edge n.
  int               cyc = 0;
  bit               cmp_en = 0;
  bit               have_step = 0;
  bit               in_idle = 1;
  bit               m_rdy = 0;
  bit               prev_start = 0;
  bit               m_err = 0;
  int               done_cyc = 0;
  int               nwin = 0;
  int               win_lo [NUM_CMDS];
  int               win_hi [NUM_CMDS];
  logic [CMD_W-1:0] win_data [NUM_CMDS];
  bit               acked [NUM_CMDS];
  int               force_q [$];
  logic [CMD_W-1:0] seen [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit busy_at(input int t);
    return have_step && (t < done_cyc);
  endfunction

  function automatic int win_of(input int t);
    for (int k = 0; k < nwin; k++)
      if (t >= win_lo[k] && t <= win_hi[k]) return k;
    return -1;
  endfunction

  // Ack delay for the next word: forced by a directed test, else random.
  function automatic int pick_delay();
    int r;
    if (force_q.size() > 0) return force_q.pop_front();
    r = int'($urandom_range(0, 9));
    if (r <= 5) return r % 4;
    if (r <= 7) return ACK_T - 1;
    if (r == 8) return ACK_T + 2;
    return int'($urandom_range(0, ACK_T - 1));
  endfunction

  task automatic plan_step(input int e);
    int eff, v, d;
    eff = (int'(cmd_count) > NUM_CMDS) ? NUM_CMDS : int'(cmd_count);
    have_step = 1; in_idle = 0; m_rdy = 0; m_err = 0; nwin = 0;
    v = e + 1;
    done_cyc = e + SETTLE_C + 1;
    for (int k = 0; k < eff; k++) begin
      d = pick_delay();
      win_lo[k]   = v;
      win_data[k] = cmd_table[k*CMD_W +: CMD_W];
      nwin++;
      if (d < ACK_T) begin
        win_hi[k] = v + d;
        acked[k]  = 1;
        if (k == eff - 1) done_cyc = v + d + SETTLE_C + 2;
        else              v = v + d + 2;
      end else begin
        win_hi[k] = v + ACK_T - 1;
        acked[k]  = 0;
        done_cyc  = v + ACK_T;
        m_err     = 1;
        break;
      end
    end
    $display("step start@%0d words=%0d sent=%0d done@%0d err=%0d", e, eff, nwin, done_cyc, m_err);
  endtask

  task automatic model_edge();
    bit re;
    if (rst) begin
      have_step = 0; in_idle = 1; m_rdy = 0; prev_start = 0; nwin = 0; m_err = 0;
      cmp_en = 1;
    end else begin
      re = seq_start && !prev_start;
      prev_start = seq_start;
      if (re && enable && !busy_at(cyc - 1)) plan_step(cyc);
      else m_rdy = in_idle ? enable : 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_edge();
    end
  end

  // Ack responder: acks on the planned cycle, random noise only outside windows.
  initial begin
    forever begin
      int w;
      @(posedge clk);
      #1;
      w = win_of(cyc);
      if (w >= 0) req_ack = acked[w] && (cyc == win_hi[w]);
      else        req_ack = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    forever begin
      int w;
      bit exp_done;
      @(negedge clk);
      if (cmp_en) begin
        w = win_of(cyc);
        exp_done = have_step && (cyc >= done_cyc);
        chk("req_valid", req_valid, w >= 0);
        if (w >= 0) chk("req_data", req_data, win_data[w]);
        else if (!have_step) chk("req_data_idle", req_data, 0);
        chk("seq_done", seq_done, exp_done);
        chk("err", err, exp_done && m_err);
        chk("seq_rdy", seq_rdy, m_rdy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise seq_start cleanly and return cycles until seq_done is seen.
  task automatic run_step(output int lat);
    bit prev_v;
    seq_start = 0;
    tick();
    seq_start = 1;
    seen.delete();
    lat = -1;
    prev_v = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (req_valid && !prev_v) seen.push_back(req_data);
      prev_v = req_valid;
      if (seq_done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL step_wait: no seq_done within 200 cycles, required done");
    end
  endtask

  initial begin
    int lat, nvalid;
    logic [CMD_W-1:0] w0;
    enable = 1;
    cmd_table = {32'hDEAD_0003, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    repeat (3) tick();
    chk("rdy_in_reset", seq_rdy, 0);
    rst = 0;
    tick(); tick();
    chk("rdy_idle", seq_rdy, 1);

    // Basic three-word step, ack two cycles after each valid
    cmd_count = 3;
    force_q = '{2, 2, 2};
    run_step(lat);
    chk("basic_latency", lat, 30);
    chk("basic_nwords", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("basic_w0", seen[0], 32'hA0);
      chk("basic_w1", seen[1], 32'hB1);
      chk("basic_w2", seen[2], 32'hC2);
    end
    chk("basic_err", err, 0);

    // Ack never comes
    cmd_count = 2;
    force_q = '{100};
    run_step(lat);
    chk("timeout_latency", lat, 10);
    chk("timeout_err", err, 1);
    chk("timeout_nwords", seen.size(), 1);

    // Ack in the cycle the timer reaches zero
    force_q = '{ACK_T - 1, 0};
    run_step(lat);
    chk("edge_latency", lat, 29);
    chk("edge_err", err, 0);
    chk("edge_nwords", seen.size(), 2);

    // Level held through DONE must not restart
    nvalid = 0;
    repeat (10) begin
      tick();
      if (req_valid) nvalid++;
    end
    chk("level_no_restart", nvalid, 0);
    chk("level_done_held", seq_done, 1);

    // Settle-only step
    cmd_count = 0;
    run_step(lat);
    chk("count0_latency", lat, 18);
    chk("count0_nwords", seen.size(), 0);

    // Count above NUM_CMDS clamps
    cmd_count = 7;
    force_q = '{0, 1, 0, 3};
    run_step(lat);
    chk("clamp_latency", lat, 30);
    chk("clamp_nwords", seen.size(), 4);
    if (seen.size() == 4) chk("clamp_w3", seen[3], 32'hDEAD_0003);

    // Reset while waiting for an ack
    cmd_count = 2;
    force_q = '{100};
    seq_start = 0;
    tick();
    seq_start = 1;
    for (int i = 0; i < 20 && !req_valid; i++) tick();
    chk("rst_test_valid_seen", req_valid, 1);
    tick(); tick();
    rst = 1;
    tick();
    chk("rst_valid", req_valid, 0);
    chk("rst_done", seq_done, 0);
    chk("rst_err", err, 0);
    chk("rst_data", req_data, 0);
    rst = 0;
    force_q = '{0, 0};
    run_step(lat);
    chk("after_rst_latency", lat, 22);
    w0 = (seen.size() > 0) ? seen[0] : '0;
    chk("after_rst_w0", w0, 32'hA0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) seq_start = ~seq_start;
      if (!busy_at(cyc) && $urandom_range(0, 3) == 0) begin
        cmd_count = CNT_W'($urandom_range(0, 7));
        for (int i = 0; i < NUM_CMDS; i++) cmd_table[i*CMD_W +: CMD_W] = $urandom();
      end
    end
    rst = 0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
